// File: rtl/slice_pkg.sv
// Shared types for the logic-slice result capture path.
// Widths, driven-bit mask, stored word bundle and occupancy states.
package slice_pkg;

  localparam int SLICE_W = 41;
  localparam int SEQ_W   = 8;

  localparam logic [SLICE_W-1:0] SLICE_DRIVEN_MASK =
    41'h00F_F000_0FF9;

  typedef struct packed {
    logic [SLICE_W-1:0] data;
    logic [SEQ_W-1:0]   seq;
  } slice_word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [SLICE_W-1:0] mask_res(
    input logic [SLICE_W-1:0] c
  );
    return c & SLICE_DRIVEN_MASK;
  endfunction

endpackage

// File: rtl/slice_result_capture_skid_buf.sv
// Two-entry skid buffer of slice_word_t with valid/ready.
// Ports: clk, rst_n, in_valid/in_ready/in_word, out_valid/out_ready/out_word.
module slice_skid_buf
  import slice_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  slice_word_t in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output slice_word_t out_word
);

  occ_e        occ;
  slice_word_t main_q;
  slice_word_t skid_q;

  logic acc;
  logic hand;

  // in_ready and out_valid are registers so the upstream
  // never sees a combinational path from out_ready.
  assign acc      = in_valid & in_ready;
  assign hand     = out_valid & out_ready;
  assign out_word = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= OCC_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (occ)
        OCC_EMPTY: begin
          if (acc) begin
            main_q    <= in_word;
            occ       <= OCC_ONE;
            out_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (acc && !hand) begin
            skid_q   <= in_word;
            occ      <= OCC_FULL;
            in_ready <= 1'b0;
          end else if (!acc && hand) begin
            occ       <= OCC_EMPTY;
            out_valid <= 1'b0;
          end else if (acc && hand) begin
            main_q <= in_word;
          end
        end
        OCC_FULL: begin
          // Older word sits in main; skid moves up on handoff.
          if (hand) begin
            main_q   <= skid_q;
            occ      <= OCC_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          occ       <= OCC_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/slice_result_capture.sv
// Registered capture of the logic-slice result vector with seq tagging.
// Ports: CK, RN, C_IN/IN_VALID/IN_READY, OUT_DATA/OUT_SEQ/OUT_VALID/OUT_READY, CLR_SEQ, OVF_CNT.
module slice_result_capture
  import slice_pkg::*;
#(
  parameter int                 WIDTH       = SLICE_W,
  parameter logic [WIDTH-1:0]   DRIVEN_MASK = SLICE_DRIVEN_MASK,
  parameter int                 SEQ_BITS    = SEQ_W
) (
  input  logic                CK,
  input  logic                RN,
  input  logic [WIDTH-1:0]    C_IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [WIDTH-1:0]    OUT_DATA,
  output logic [SEQ_BITS-1:0] OUT_SEQ,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  input  logic                CLR_SEQ,
  output logic [SEQ_BITS-1:0] OVF_CNT
);

  localparam logic [SEQ_BITS-1:0] TAG_ONE = 1;

  logic [SEQ_BITS-1:0] tag;
  logic [SEQ_BITS-1:0] ovf;
  logic                acc;
  slice_word_t         in_w;
  slice_word_t         out_w;

  assign acc       = IN_VALID & IN_READY;
  assign in_w.data = C_IN & DRIVEN_MASK;
  assign in_w.seq  = tag;

  slice_skid_buf u_skid (
    .clk       (CK),
    .rst_n     (RN),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .in_word   (in_w),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_word  (out_w)
  );

  assign OUT_DATA = out_w.data;
  assign OUT_SEQ  = out_w.seq;
  assign OVF_CNT  = ovf;

  // The accepted word has already latched the old tag,
  // so a same-cycle clear simply overrides the increment.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      tag <= '0;
      ovf <= '0;
    end else begin
      if (acc) begin
        tag <= tag + TAG_ONE;
        if ((&tag) && !(&ovf))
          ovf <= ovf + TAG_ONE;
      end
      if (CLR_SEQ)
        tag <= '0;
    end
  end

endmodule

// File: tb/tb_slice_result_capture.sv
// Directed bench for slice_result_capture.
// Drives and samples on the falling edge; checks with immediate assertions.
module tb_slice_result_capture;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic [40:0] C_IN = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [40:0] OUT_DATA;
  logic [7:0]  OUT_SEQ;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic        CLR_SEQ = 1'b0;
  logic [7:0]  OVF_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [40:0] MASK = 41'h00F_F000_0FF9;

  always #5 CK = ~CK;

  slice_result_capture dut (
    .CK        (CK),
    .RN        (RN),
    .C_IN      (C_IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_SEQ   (OUT_SEQ),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .CLR_SEQ   (CLR_SEQ),
    .OVF_CNT   (OVF_CNT)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    @(negedge CK);
  endtask

  initial begin
    // 1 reset with valid asserted
    IN_VALID = 1'b1;
    C_IN = 41'h123;
    @(negedge CK);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out_data", 64'(OUT_DATA), 64'd0);
    chk("rst_out_seq", 64'(OUT_SEQ), 64'd0);
    chk("rst_ovf", 64'(OVF_CNT), 64'd0);
    IN_VALID = 1'b0;
    RN = 1'b1;

    // 2 masking
    C_IN = 41'h1FF_FFFF_FFFF;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("mask_valid", 64'(OUT_VALID), 64'd1);
    chk("mask_data", 64'(OUT_DATA), 64'(MASK));
    chk("mask_seq", 64'(OUT_SEQ), 64'd0);
    step();
    chk("mask_drain", 64'(OUT_VALID), 64'd0);

    // 3 backpressure; clear tag so the run starts at 0
    CLR_SEQ = 1'b1;
    step();
    CLR_SEQ = 1'b0;
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    C_IN = 41'h1;
    step();
    chk("bp_rdy1", 64'(IN_READY), 64'd1);
    C_IN = 41'h8;
    step();
    chk("bp_full_rdy", 64'(IN_READY), 64'd0);
    C_IN = 41'h10;
    step();
    chk("bp_hold_rdy", 64'(IN_READY), 64'd0);
    chk("bp_hold_data", 64'(OUT_DATA), 64'h1);
    chk("bp_hold_seq", 64'(OUT_SEQ), 64'd0);
    OUT_READY = 1'b1;
    step();
    chk("bp_w1_data", 64'(OUT_DATA), 64'h8);
    chk("bp_w1_seq", 64'(OUT_SEQ), 64'd1);
    chk("bp_w1_rdy", 64'(IN_READY), 64'd1);
    step();
    IN_VALID = 1'b0;
    chk("bp_w2_data", 64'(OUT_DATA), 64'h10);
    chk("bp_w2_seq", 64'(OUT_SEQ), 64'd2);
    chk("bp_w2_valid", 64'(OUT_VALID), 64'd1);
    step();
    chk("bp_empty", 64'(OUT_VALID), 64'd0);

    // 4 tag wrap and overflow saturation
    CLR_SEQ = 1'b1;
    step();
    CLR_SEQ = 1'b0;
    IN_VALID = 1'b1;
    C_IN = 41'h9;
    for (int i = 0; i < 256; i++) step();
    chk("wrap_seq255", 64'(OUT_SEQ), 64'd255);
    chk("wrap_ovf1", 64'(OVF_CNT), 64'd1);
    step();
    chk("wrap_seq0", 64'(OUT_SEQ), 64'd0);
    chk("wrap_ovf_keep", 64'(OVF_CNT), 64'd1);
    for (int i = 0; i < 256 * 255; i++) step();
    chk("sat_ovf", 64'(OVF_CNT), 64'd255);
    for (int i = 0; i < 256; i++) step();
    chk("sat_hold", 64'(OVF_CNT), 64'd255);
    IN_VALID = 1'b0;
    step();

    // 5 clear coincident with accept at tag 5
    CLR_SEQ = 1'b1;
    step();
    CLR_SEQ = 1'b0;
    IN_VALID = 1'b1;
    C_IN = 41'h1;
    for (int i = 0; i < 5; i++) step();
    chk("clr_pre_seq", 64'(OUT_SEQ), 64'd4);
    C_IN = 41'hFF8;
    CLR_SEQ = 1'b1;
    step();
    CLR_SEQ = 1'b0;
    chk("clr_old_seq", 64'(OUT_SEQ), 64'd5);
    chk("clr_old_data", 64'(OUT_DATA), 64'hFF8);
    C_IN = 41'h0F_F000_0000;
    step();
    chk("clr_new_seq", 64'(OUT_SEQ), 64'd0);
    chk("clr_new_data", 64'(OUT_DATA), 64'h0F_F000_0000);
    chk("clr_ovf", 64'(OVF_CNT), 64'd255);
    IN_VALID = 1'b0;
    step();

    // 6 async reset while full
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    C_IN = 41'h1;
    step();
    C_IN = 41'h8;
    step();
    IN_VALID = 1'b0;
    chk("ar_full", 64'(IN_READY), 64'd0);
    chk("ar_valid_pre", 64'(OUT_VALID), 64'd1);
    #2 RN = 1'b0;
    #1;
    chk("ar_valid", 64'(OUT_VALID), 64'd0);
    chk("ar_rdy", 64'(IN_READY), 64'd1);
    chk("ar_data", 64'(OUT_DATA), 64'd0);
    chk("ar_ovf", 64'(OVF_CNT), 64'd0);
    @(negedge CK);
    RN = 1'b1;
    OUT_READY = 1'b1;
    step();
    chk("ar_lost", 64'(OUT_VALID), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
